// File: rtl/maint_scheduler_if.sv
// Crew-scheduler bus: per-machine done pulses in,
// one-hot grant, overdue flags, FSM state, granted age, overdue count out.
interface maint_scheduler_if #(
  parameter int N_MACH = 4
);
  logic [N_MACH-1:0] done;
  logic [N_MACH-1:0] grant;
  logic [N_MACH-1:0] overdue;
  logic [1:0]        current_state;
  logic [7:0]        reg_state;
  logic [7:0]        ovd_count;

  modport master (
    output done,
    input  grant, overdue, current_state,
    input  reg_state, ovd_count
  );

  modport slave (
    input  done,
    output grant, overdue, current_state,
    output reg_state, ovd_count
  );
endinterface

// File: rtl/maint_scheduler.sv
// Shares one maintenance crew between N_MACH machines with per-machine
// age timers: raises requests at PERIOD, flags overdue at PERIOD+GRACE,
// grants the crew one-hot round-robin (overdue machines first) and waits
// for the granted machine's done pulse, then cools down one cycle.
// Ports: clk, rst (async active-low), bus (slave: done in; grant,
// overdue, current_state, reg_state, ovd_count out).
// MAINT_OVD_COUNT_EN: when defined, ovd_count counts overdue events;
// otherwise it is tied to zero.
module maint_scheduler #(
  parameter int N_MACH = 4,
  parameter int PERIOD = 9,
  parameter int GRACE  = 10
) (
  input logic              clk,
  input logic              rst,
  maint_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_COOL  = 2'd2;
  localparam int PW = $clog2(N_MACH);
  localparam logic [7:0] P_AGE   = 8'(PERIOD);
  localparam logic [7:0] OVD_PRE = 8'(PERIOD + GRACE - 1);

  logic [7:0]        age_q [N_MACH];
  logic [7:0]        age_d [N_MACH];
  logic [N_MACH-1:0] ovd_q, ovd_d;
  logic [N_MACH-1:0] grant_q, grant_d;
  logic [N_MACH-1:0] req, serve, mask;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     g_q, g_d, win;
  logic [1:0]        st_q, st_d;
  logic              served;

  // First set bit of m searching upward from p+1 with wrap.
  function automatic logic [PW-1:0] rr_pick(
    input logic [N_MACH-1:0] m,
    input logic [PW-1:0]     p
  );
    logic [PW-1:0] w;
    logic          hit;
    int            idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 1; k <= N_MACH; k++) begin
      idx = int'(p) + k;
      if (idx >= N_MACH) idx = idx - N_MACH;
      if (!hit && m[idx[PW-1:0]]) begin
        hit = 1'b1;
        w   = idx[PW-1:0];
      end
    end
    return w;
  endfunction

  always_comb begin
    served = (st_q == S_GRANT) && bus.done[g_q];
    serve  = '0;
    if (served) serve[g_q] = 1'b1;
    for (int i = 0; i < N_MACH; i++) begin
      req[i] = age_q[i] >= P_AGE;
      // Service clear takes priority over the overdue set.
      if (serve[i]) begin
        age_d[i] = 8'd0;
        ovd_d[i] = 1'b0;
      end else begin
        age_d[i] = (age_q[i] == 8'hff) ? age_q[i]
                                       : age_q[i] + 8'd1;
        ovd_d[i] = ovd_q[i] || (age_q[i] == OVD_PRE);
      end
    end
    mask    = (|(req & ovd_q)) ? (req & ovd_q) : req;
    win     = rr_pick(mask, ptr_q);
    st_d    = st_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    unique case (st_q)
      S_IDLE: begin
        if (|req) begin
          st_d       = S_GRANT;
          g_d        = win;
          grant_d    = '0;
          grant_d[win] = 1'b1;
        end
      end
      S_GRANT: begin
        if (served) begin
          st_d    = S_COOL;
          grant_d = '0;
          ptr_d   = g_q;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_MACH; i++) age_q[i] <= 8'd0;
      ovd_q   <= '0;
      grant_q <= '0;
      ptr_q   <= PW'(N_MACH - 1);
      g_q     <= '0;
      st_q    <= S_IDLE;
    end else begin
      for (int i = 0; i < N_MACH; i++) age_q[i] <= age_d[i];
      ovd_q   <= ovd_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      st_q    <= st_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.overdue       = ovd_q;
  assign bus.current_state = st_q;
  assign bus.reg_state     = (|grant_q) ? age_q[g_q] : 8'd0;

`ifdef MAINT_OVD_COUNT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic [N_MACH-1:0] ovd_rise;

  always_comb begin
    ovd_rise = ovd_d & ~ovd_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_MACH; i++) begin
      if (ovd_rise[i] && cnt_d != 8'hff) cnt_d = cnt_d + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end

  assign bus.ovd_count = cnt_q;
`else
  assign bus.ovd_count = 8'd0;
`endif
endmodule

// File: tb/tb_maint_scheduler.sv
// Self-checking bench for maint_scheduler: directed vector table,
// async-reset and clear-wins sequences, then random done vs a model.
module tb_maint_scheduler;
  localparam int N = 4;
  localparam int P = 9;
  localparam int G = 10;
`ifdef MAINT_OVD_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  maint_scheduler_if #(.N_MACH(N)) bus ();

  maint_scheduler #(
    .N_MACH(N), .PERIOD(P), .GRACE(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] d;
    logic [3:0] g;
    logic [1:0] st;
    logic [7:0] rs;
    logic [3:0] ovd;
    logic [7:0] cnt;
  } tv_t;
  tv_t tv[$];

  int m_age [N];
  bit m_ovd [N];
  int m_st, m_g, m_ptr, m_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < N; i++) begin
      m_age[i] = 0;
      m_ovd[i] = 0;
    end
    m_st = 0; m_g = -1; m_ptr = N - 1; m_cnt = 0;
  endfunction

  function automatic int pick();
    int idx;
    for (int pass = 0; pass < 2; pass++)
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (m_age[idx] >= P && (pass == 1 || m_ovd[idx])) return idx;
      end
    return -1;
  endfunction

  function automatic void mdl_step(input logic [N-1:0] d);
    int sg, w;
    sg = -1;
    if (m_st == 1 && d[m_g]) sg = m_g;
    w = pick();
    case (m_st)
      0: if (w >= 0) begin m_st = 1; m_g = w; end
      1: if (sg >= 0) begin m_ptr = m_g; m_g = -1; m_st = 2; end
      default: m_st = 0;
    endcase
    for (int i = 0; i < N; i++) begin
      if (i == sg) begin
        m_age[i] = 0;
        m_ovd[i] = 0;
      end else begin
        if (m_age[i] + 1 == P + G && !m_ovd[i]) begin
          m_ovd[i] = 1;
          if (m_cnt < 255) m_cnt++;
        end
        if (m_age[i] < 255) m_age[i]++;
      end
    end
  endfunction

  task automatic check_model(input string tag);
    int eg, eo;
    eg = (m_st == 1) ? (1 << m_g) : 0;
    eo = 0;
    for (int i = 0; i < N; i++) if (m_ovd[i]) eo |= (1 << i);
    chk({tag, ".grant"}, int'(bus.grant), eg);
    chk({tag, ".overdue"}, int'(bus.overdue), eo);
    chk({tag, ".state"}, int'(bus.current_state), m_st);
    chk({tag, ".reg_state"}, int'(bus.reg_state),
        (m_st == 1) ? m_age[m_g] : 0);
    chk({tag, ".ovd_count"}, int'(bus.ovd_count), CNT_EN ? m_cnt : 0);
  endtask

  task automatic step(input logic [N-1:0] d);
    bus.done = d;
    @(posedge clk);
    if (rst) mdl_step(d);
    #1;
  endtask

  task automatic do_reset();
    bus.done = '0;
    rst = 1'b0;
    mdl_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic void add(input logic [3:0] d, input logic [3:0] g,
                              input logic [1:0] st, input int rs,
                              input logic [3:0] ovd, input int cnt);
    tv_t t;
    t.d = d; t.g = g; t.st = st; t.rs = 8'(rs); t.ovd = ovd;
    t.cnt = CNT_EN ? 8'(cnt) : 8'd0;
    tv.push_back(t);
  endfunction

  initial begin
    bus.done = '0;
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 10, 0, 0);
    for (int k = 11; k <= 18; k++) add(0, 1, 1, k, 0, 0);
    add(0, 1, 1, 19, 15, 4);
    add(1, 0, 2, 0, 14, 4);
    add(0, 0, 0, 0, 14, 4);
    add(0, 2, 1, 22, 14, 4);
    add(12, 2, 1, 23, 14, 4);
    add(0, 2, 1, 24, 14, 4);
    add(2, 0, 2, 0, 12, 4);
    add(0, 0, 0, 0, 12, 4);
    add(0, 4, 1, 27, 12, 4);

    #3;
    chk("rst.grant", int'(bus.grant), 0);
    chk("rst.state", int'(bus.current_state), 0);
    chk("rst.ovd_count", int'(bus.ovd_count), 0);
    do_reset();

    foreach (tv[i]) begin
      step(tv[i].d);
      chk($sformatf("tv%0d.grant", i), int'(bus.grant), int'(tv[i].g));
      chk($sformatf("tv%0d.state", i), int'(bus.current_state),
          int'(tv[i].st));
      chk($sformatf("tv%0d.reg", i), int'(bus.reg_state), int'(tv[i].rs));
      chk($sformatf("tv%0d.ovd", i), int'(bus.overdue), int'(tv[i].ovd));
      chk($sformatf("tv%0d.cnt", i), int'(bus.ovd_count), int'(tv[i].cnt));
    end

    // Async reset while granted: outputs clear before the next edge.
    rst = 1'b0;
    #2;
    chk("arst.grant", int'(bus.grant), 0);
    chk("arst.overdue", int'(bus.overdue), 0);
    chk("arst.reg_state", int'(bus.reg_state), 0);
    chk("arst.state", int'(bus.current_state), 0);
    mdl_reset();
    @(negedge clk);
    rst = 1'b1;

    // Service lands on the edge where age 0 would turn overdue.
    for (int k = 1; k <= 18; k++) begin
      step('0);
      check_model("seq");
    end
    step(4'b0001);
    chk("clrwin.overdue", int'(bus.overdue), 4'b1110);
    chk("clrwin.cnt", int'(bus.ovd_count), CNT_EN ? 3 : 0);
    check_model("clrwin");

    // Long hold in GRANT: ages saturate at 255.
    for (int k = 0; k < 300; k++) begin
      step('0);
      check_model("hold");
    end
    chk("sat.reg_state", int'(bus.reg_state), 255);

    for (int k = 0; k < 1500; k++) begin
      if (k == 700) do_reset();
      step(($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0);
      check_model("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
